ddr3_partial_write_ctrl: RTL and testbench

//  Single-request scheduler in front of ddr3_partial_seq. Accepts one write job (bank/row/col/data/cycle count),

---
 rtl/ddr3_partial_write_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_ddr3_partial_write_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_partial_write_ctrl.sv
`default_nettype none
// =====================================================================
// Module : ddr3_partial_write_ctrl
// Single-job ACT -> WRITE -> PRE scheduler with partial-write controls.
// Option : DDR3_PWC_READBACK_EN adds an ACT -> READ -> PRE verify pass.
// Rev    : 1.0  initial release
// =====================================================================
module ddr3_partial_write_ctrl #(
   parameter int T_RCD = 3,
   parameter int T_RAS = 6,
   parameter int T_WR  = 8,
   parameter int T_RP  = 3,
   parameter int CNT_W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic [2:0]   req_bank_i,
   input  logic [14:0]  req_row_i,
   input  logic [9:0]   req_col_i,
   input  logic [127:0] req_data_i,
   input  logic [15:0]  req_mask_i,
   input  logic [2:0]   req_cycles_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [3:0]   seq_command_o,
   output logic [14:0]  seq_address_o,
   output logic [2:0]   seq_bank_o,
   output logic         seq_cke_o,
   output logic [127:0] seq_wrdata_o,
   output logic [15:0]  seq_wrdata_mask_o,
   input  logic         seq_accept_i,
   output logic         pw_en_o,
   output logic [2:0]   pw_cycles_o
`ifdef DDR3_PWC_READBACK_EN
   ,
   input  logic [127:0] seq_rddata_i,
   input  logic         seq_rddata_valid_i,
   output logic         rb_mismatch_o
`endif
);

   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_PRE   = 4'b0010;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] RCD_LD  = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0] RAS_LD  = CNT_W'(T_RAS - 1);
   localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(T_WR - 1);
   localparam logic [CNT_W-1:0] RP_LD   = CNT_W'(T_RP - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ACT, S_W_RCD, S_WR, S_W_WR, S_PRE, S_W_RP, S_DONE, S_RD, S_W_DATA
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] ras_q, ras_d;
   logic             cke_q, cke_d;
   logic             rdy_en_q, rdy_en_d;
   logic [2:0]       bank_q, bank_d;
   logic [14:0]      row_q, row_d;
   logic [9:0]       col_q, col_d;
   logic [127:0]     data_q, data_d;
   logic [15:0]      mask_q, mask_d;
   logic [2:0]       cycles_q, cycles_d;
`ifdef DDR3_PWC_READBACK_EN
   logic             rb_phase_q, rb_phase_d;
   logic             rb_mis_q, rb_mis_d;
   logic             rb_diff;

   // Only bytes that were actually written (unmasked, inside the first N beats) take part.
   always_comb begin
      rb_diff = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!mask_q[i] && (cycles_q == 3'd0 || i < 2 * int'(cycles_q)) &&
             seq_rddata_i[8*i +: 8] != data_q[8*i +: 8])
            rb_diff = 1'b1;
      end
   end

   assign rb_mismatch_o = rb_mis_q;
`endif

   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      ras_d         = (ras_q != '0) ? ras_q - CNT_ONE : ras_q;
      cke_d         = 1'b1;
      rdy_en_d      = cke_q;
      bank_d        = bank_q;
      row_d         = row_q;
      col_d         = col_q;
      data_d        = data_q;
      mask_d        = mask_q;
      cycles_d      = cycles_q;
      seq_command_o = CMD_NOP;
      seq_address_o = '0;
      seq_bank_o    = '0;
      pw_en_o       = 1'b0;
      pw_cycles_o   = '0;
      done_o        = 1'b0;
      req_ready_o   = (state_q == S_IDLE) && rdy_en_q;
`ifdef DDR3_PWC_READBACK_EN
      rb_phase_d    = rb_phase_q;
      rb_mis_d      = seq_rddata_valid_i ? rb_diff : rb_mis_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req_valid_i && req_ready_o) begin
               bank_d   = req_bank_i;
               row_d    = req_row_i;
               col_d    = req_col_i;
               data_d   = req_data_i;
               mask_d   = req_mask_i;
               cycles_d = req_cycles_i;
               state_d  = S_ACT;
`ifdef DDR3_PWC_READBACK_EN
               rb_phase_d = 1'b0;
               rb_mis_d   = 1'b0;
`endif
            end
         end
         S_ACT: begin
            seq_command_o = CMD_ACT;
            seq_address_o = row_q;
            seq_bank_o    = bank_q;
            if (seq_accept_i) begin
               tmr_d   = RCD_LD;
               ras_d   = RAS_LD;
               state_d = S_W_RCD;
            end
         end
         S_W_RCD: begin
            if (tmr_q <= CNT_ONE) begin
`ifdef DDR3_PWC_READBACK_EN
               state_d = rb_phase_q ? S_RD : S_WR;
`else
               state_d = S_WR;
`endif
            end else begin
               tmr_d = tmr_q - CNT_ONE;
            end
         end
         S_WR: begin
            seq_command_o = CMD_WRITE;
            seq_address_o = {4'b0, 1'b0, col_q};
            seq_bank_o    = bank_q;
            pw_en_o       = (cycles_q != 3'd0);
            pw_cycles_o   = cycles_q;
            if (seq_accept_i) begin
               tmr_d   = WR_LD;
               state_d = S_W_WR;
            end
         end
         S_W_WR: begin
            pw_en_o     = (cycles_q != 3'd0);
            pw_cycles_o = cycles_q;
            if (tmr_q > CNT_ONE) tmr_d = tmr_q - CNT_ONE;
            // Precharge needs both write recovery and the row-active minimum.
            if (tmr_q <= CNT_ONE && ras_q <= CNT_ONE) state_d = S_PRE;
         end
         S_PRE: begin
            seq_command_o = CMD_PRE;
            seq_bank_o    = bank_q;
            if (seq_accept_i) begin
               tmr_d   = RP_LD;
               state_d = S_W_RP;
            end
         end
         S_W_RP: begin
            if (tmr_q <= CNT_ONE) begin
`ifdef DDR3_PWC_READBACK_EN
               if (!rb_phase_q) begin
                  rb_phase_d = 1'b1;
                  state_d    = S_ACT;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end else begin
               tmr_d = tmr_q - CNT_ONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
`ifdef DDR3_PWC_READBACK_EN
         S_RD: begin
            seq_command_o = CMD_READ;
            seq_address_o = {4'b0, 1'b0, col_q};
            seq_bank_o    = bank_q;
            if (seq_accept_i) begin
               tmr_d   = WR_LD;
               state_d = S_W_DATA;
            end
         end
         S_W_DATA: begin
            if (tmr_q > CNT_ONE) tmr_d = tmr_q - CNT_ONE;
            if (tmr_q <= CNT_ONE && ras_q <= CNT_ONE) state_d = S_PRE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         ras_q    <= '0;
         cke_q    <= 1'b0;
         rdy_en_q <= 1'b0;
         bank_q   <= '0;
         row_q    <= '0;
         col_q    <= '0;
         data_q   <= '0;
         mask_q   <= 16'hFFFF;
         cycles_q <= '0;
`ifdef DDR3_PWC_READBACK_EN
         rb_phase_q <= 1'b0;
         rb_mis_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         ras_q    <= ras_d;
         cke_q    <= cke_d;
         rdy_en_q <= rdy_en_d;
         bank_q   <= bank_d;
         row_q    <= row_d;
         col_q    <= col_d;
         data_q   <= data_d;
         mask_q   <= mask_d;
         cycles_q <= cycles_d;
`ifdef DDR3_PWC_READBACK_EN
         rb_phase_q <= rb_phase_d;
         rb_mis_q   <= rb_mis_d;
`endif
      end
   end

   assign busy_o            = (state_q != S_IDLE);
   assign seq_cke_o         = cke_q;
   assign seq_wrdata_o      = data_q;
   assign seq_wrdata_mask_o = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_partial_write_ctrl.sv
`default_nettype none
// Testbench for ddr3_partial_write_ctrl: randomized jobs checked by a scoreboard
// against DDR3 timing rules (command order, issue cycles, partial-write window).
module tb_ddr3_partial_write_ctrl;
   localparam int T_RCD = 3, T_RAS = 6, T_WR = 8, T_RP = 3;
   localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WRC = 4'b0100,
                          RDC = 4'b0101, PRE = 4'b0010, DONE_EV = 4'b1111;

   logic         clk_i = 1'b0, rst_ni = 1'b0;
   logic         req_valid_i = 1'b0, req_ready_o;
   logic [2:0]   req_bank_i = '0;
   logic [14:0]  req_row_i = '0;
   logic [9:0]   req_col_i = '0;
   logic [127:0] req_data_i = '0;
   logic [15:0]  req_mask_i = '0;
   logic [2:0]   req_cycles_i = '0;
   logic         busy_o, done_o, seq_cke_o, pw_en_o;
   logic [3:0]   seq_command_o;
   logic [14:0]  seq_address_o;
   logic [2:0]   seq_bank_o, pw_cycles_o;
   logic [127:0] seq_wrdata_o;
   logic [15:0]  seq_wrdata_mask_o;
   logic         seq_accept_i = 1'b0;
`ifdef DDR3_PWC_READBACK_EN
   logic [127:0] seq_rddata_i = '0;
   logic         seq_rddata_valid_i = 1'b0;
   logic         rb_mismatch_o;
   bit           exp_mis = 1'b0;
`endif

   ddr3_partial_write_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_bank_i(req_bank_i), .req_row_i(req_row_i), .req_col_i(req_col_i),
      .req_data_i(req_data_i), .req_mask_i(req_mask_i), .req_cycles_i(req_cycles_i),
      .busy_o(busy_o), .done_o(done_o),
      .seq_command_o(seq_command_o), .seq_address_o(seq_address_o), .seq_bank_o(seq_bank_o),
      .seq_cke_o(seq_cke_o), .seq_wrdata_o(seq_wrdata_o), .seq_wrdata_mask_o(seq_wrdata_mask_o),
      .seq_accept_i(seq_accept_i), .pw_en_o(pw_en_o), .pw_cycles_o(pw_cycles_o)
`ifdef DDR3_PWC_READBACK_EN
      , .seq_rddata_i(seq_rddata_i), .seq_rddata_valid_i(seq_rddata_valid_i),
      .rb_mismatch_o(rb_mismatch_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [3:0] cmd; logic [14:0] addr; logic [2:0] bank; } ev_t;
   ev_t          exp_q[$];
   int           checks = 0, failures = 0, cyc = 0;
   logic [127:0] job_data;
   logic [15:0]  job_mask;
   logic [2:0]   job_cyc;
   bit           rand_accept = 1'b0, first_act = 1'b0, in_wr = 1'b0, cmd_active = 1'b0;
   bit           wr_acc_seen = 1'b0, rb_corrupt = 1'b0;
   int           act_stall = 0, cap_cyc = 0, act_acc = 0, act_start_rec = 0;
   int           cas_acc = 0, pre_acc = 0, done_cnt = 0, cur_start = 0;
   logic [3:0]   cur_cmd = NOP;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      #2;
   endtask

   function automatic bit byte_written(input int k);
      return !job_mask[k] && (job_cyc == 3'd0 || k < 2 * int'(job_cyc));
   endfunction

   // Scoreboard monitor: pops expected commands as they appear and checks issue timing.
   always @(negedge clk_i) begin : monitor
      ev_t e;
      int  exp_start;
      if (!rst_ni) begin
         exp_q.delete();
         cmd_active = 1'b0;
         in_wr      = 1'b0;
      end else begin
         if (cmd_active) begin
            chk("cmd_held_until_accept", seq_command_o, cur_cmd);
         end else if (seq_command_o != NOP) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_cmd", seq_command_o, NOP);
            end else begin
               e = exp_q.pop_front();
               chk("cmd", seq_command_o, e.cmd);
               chk("addr", seq_address_o, e.addr);
               chk("bank", seq_bank_o, e.bank);
               exp_start = 0;
               case (seq_command_o)
                  ACT: exp_start = first_act ? cap_cyc + 1 : pre_acc + T_RP;
                  WRC, RDC: exp_start = act_acc + T_RCD;
                  default: exp_start = (act_acc + T_RAS > cas_acc + T_WR) ? act_acc + T_RAS
                                                                           : cas_acc + T_WR;
               endcase
               chk("issue_cycle", cyc, exp_start);
               if (seq_command_o == WRC) begin
                  in_wr = 1'b1;
                  chk("wrdata", seq_wrdata_o, job_data);
                  chk("wrmask", seq_wrdata_mask_o, job_mask);
               end
               if (seq_command_o == PRE) in_wr = 1'b0;
            end
            cur_cmd    = seq_command_o;
            cur_start  = cyc;
            cmd_active = 1'b1;
         end
         if (cmd_active && seq_accept_i) begin
            cmd_active = 1'b0;
            case (cur_cmd)
               ACT: begin act_acc = cyc; act_start_rec = cur_start; first_act = 1'b0; end
               WRC: begin cas_acc = cyc; wr_acc_seen = 1'b1; end
               RDC: cas_acc = cyc;
               default: pre_acc = cyc;
            endcase
         end
         chk("pw_en", pw_en_o, in_wr && (job_cyc != 3'd0));
         chk("pw_cycles", pw_cycles_o, in_wr ? job_cyc : 3'd0);
         if (done_o) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", done_o, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("done_order", DONE_EV, e.cmd);
               chk("done_cycle", cyc, pre_acc + T_RP);
`ifdef DDR3_PWC_READBACK_EN
               chk("rb_mismatch", rb_mismatch_o, exp_mis);
`endif
            end
            done_cnt++;
         end
      end
   end

   // Sequencer accept model: forced ACT stalls, random back-pressure, or always ready.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (act_stall > 0 && seq_command_o == ACT) begin
            seq_accept_i = 1'b0;
            act_stall--;
         end else if (rand_accept) begin
            seq_accept_i = ($urandom_range(0, 2) != 0);
         end else begin
            seq_accept_i = 1'b1;
         end
      end
   end

`ifdef DDR3_PWC_READBACK_EN
   initial begin
      forever begin
         logic [127:0] rd;
         int           k;
         @(negedge clk_i);
         if (rst_ni && seq_command_o == RDC && seq_accept_i) begin
            rd = job_data;
            exp_mis = 1'b0;
            if (rb_corrupt) begin
               k = $urandom_range(0, 15);
               rd[8*k +: 8] = ~rd[8*k +: 8];
               exp_mis = byte_written(k);
            end
            repeat (3) @(posedge clk_i);
            #1;
            seq_rddata_i = rd;
            seq_rddata_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            seq_rddata_valid_i = 1'b0;
         end
      end
   end
`endif

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd"}, seq_command_o, NOP);
      chk({tag, "_addr"}, seq_address_o, 15'd0);
      chk({tag, "_bank"}, seq_bank_o, 3'd0);
      chk({tag, "_data"}, seq_wrdata_o, 128'd0);
      chk({tag, "_mask"}, seq_wrdata_mask_o, 16'hFFFF);
      chk({tag, "_cke"}, seq_cke_o, 1'b0);
      chk({tag, "_pw"}, {pw_en_o, pw_cycles_o}, 4'd0);
      chk({tag, "_ready"}, req_ready_o, 1'b0);
      chk({tag, "_busy_done"}, {busy_o, done_o}, 2'd0);
`ifdef DDR3_PWC_READBACK_EN
      chk({tag, "_rbmis"}, rb_mismatch_o, 1'b0);
`endif
   endtask

   task automatic release_reset();
      rst_ni = 1'b1;
      tick();
      chk("cke_after_release", seq_cke_o, 1'b1);
      chk("ready_one_cycle_after_release", req_ready_o, 1'b0);
      tick();
      chk("ready_after_release", req_ready_o, 1'b1);
   endtask

   task automatic run_job(input logic [2:0] b, input logic [14:0] r, input logic [9:0] c,
                          input logic [127:0] d, input logic [15:0] m, input logic [2:0] n,
                          input bit poke, input bit corrupt, input bit abort);
      int t, dc;
      t = 0;
      while (!req_ready_o && t < 50) begin tick(); t++; end
      chk("ready_before_job", req_ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      job_data = d; job_mask = m; job_cyc = n; rb_corrupt = corrupt;
      first_act = 1'b1; wr_acc_seen = 1'b0; cap_cyc = cyc;
      exp_q.push_back('{ACT, r, b});
      exp_q.push_back('{WRC, {5'b0, c}, b});
      exp_q.push_back('{PRE, 15'd0, b});
`ifdef DDR3_PWC_READBACK_EN
      exp_q.push_back('{ACT, r, b});
      exp_q.push_back('{RDC, {5'b0, c}, b});
      exp_q.push_back('{PRE, 15'd0, b});
`endif
      exp_q.push_back('{DONE_EV, 15'd0, 3'd0});
      req_valid_i = 1'b1; req_bank_i = b; req_row_i = r; req_col_i = c;
      req_data_i = d; req_mask_i = m; req_cycles_i = n;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      req_data_i  = {4{$urandom}};
      chk("busy_after_capture", busy_o, 1'b1);
      chk("ready_low_while_busy", req_ready_o, 1'b0);
      if (poke) begin
         repeat (2) @(posedge clk_i);
         #1;
         req_valid_i = 1'b1; req_col_i = c ^ 10'h3F8; req_row_i = r ^ 15'h1;
         req_bank_i = b ^ 3'h1; req_cycles_i = n ^ 3'h3;
         repeat (3) @(posedge clk_i);
         #1;
         req_valid_i = 1'b0;
      end
      if (abort) begin
         t = 0;
         while (!wr_acc_seen && t < 100) begin tick(); t++; end
         chk("abort_write_accepted", wr_acc_seen, 1'b1);
         tick();
         chk("abort_pw_before_reset", {pw_en_o, pw_cycles_o}, {n != 3'd0, n});
         rst_ni = 1'b0;
         #1;
         chk_reset_vals("abort");
         tick();
         return;
      end
      dc = done_cnt;
      t = 0;
      while (done_cnt == dc && t < 400) begin tick(); t++; end
      chk("done_seen", done_cnt, dc + 1);
      tick();
      chk("idle_after_done", {busy_o, req_ready_o}, 2'b01);
      repeat (3) tick();
      chk("done_once", done_cnt, dc + 1);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      tick();
      chk_reset_vals("reset");
      repeat (2) tick();
      release_reset();

      run_job(3'd2, 15'h1234, 10'h008, {4{$urandom}}, 16'h0000, 3'd0, 0, 0, 0);
      run_job(3'd5, 15'h0ABC, 10'h1F0, {4{$urandom}}, 16'h00F0, 3'd2, 0, 1, 0);
      act_stall = 5;
      run_job(3'd1, 15'h7001, 10'h040, {4{$urandom}}, 16'h8001, 3'd4, 0, 0, 0);
      chk("act_held_cycles", act_acc - act_start_rec, 5);
      act_stall = 0;
      run_job(3'd6, 15'h2222, 10'h3C8, {4{$urandom}}, 16'h0000, 3'd7, 1, 1, 0);

      rand_accept = 1'b1;
      for (int j = 0; j < 12; j++) begin
         run_job(3'($urandom_range(0, 7)), 15'($urandom), {7'($urandom), 3'b000},
                 {4{$urandom}}, 16'($urandom), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 0);
      end

      rand_accept = 1'b0;
      run_job(3'd4, 15'h0F0F, 10'h100, {4{$urandom}}, 16'h0000, 3'd5, 0, 0, 1);
      release_reset();
      run_job(3'd3, 15'h4321, 10'h018, {4{$urandom}}, 16'h0000, 3'd0, 0, 0, 0);
      run_job(3'd3, 15'h4322, 10'h020, {4{$urandom}}, 16'h0000, 3'd3, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
